bus_cycle_ctrl: RTL and testbench
=================================

# bus_cycle_ctrl

External bus cycle sequencer for the bus interface unit. Takes a 20-bit physical address, produced by the address ALU from segment:offset, together with a read, write or code-fetch request. It runs an 8086-style T1–T4 bus cycle with READY-driven wait states. On code fetches it returns the byte and pulses the instruction queue's load enable. It sits between the address ALU and the I/O buffer and queue.

## Interface

Parameters:
- `MAX_WAIT`, default 15: maximum number of TW states before timeout. Used only when `BUS_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req` in 1: cycle request. Sampled only in IDLE.
- `wr` in 1: 1 = write cycle, 0 = read cycle.
- `fetch` in 1: read is a code fetch. Ignored when `wr` = 1.
- `addr` in 20: physical address.
- `wdata` in 8: write data.
- `ready` in 1: memory ready, sampled in T3 and TW.
- `data_in` in 8: byte from the internal side of the I/O buffer.
- `busy` out 1: cycle in progress (T1 through T4).
- `done` out 1: one-cycle pulse in T4.
- `timeout` out 1: one-cycle pulse in T4 of an aborted cycle.
- `rdata` out 8: captured read byte.
- `q_en` out 1: queue load enable, one-cycle pulse.
- `ale` out 1: address latch enable.
- `addr_bus` out 20: latched address.
- `rd_n` out 1: read strobe, active-low.
- `wr_n` out 1: write strobe, active-low.
- `den_n` out 1: data enable, active-low.
- `dt_r` out 1: 1 = receive, 0 = transmit.
- `data_oe` out 1: drive `data_out` onto the bus.
- `data_out` out 8: write byte.

## Operation

States and transitions:
- IDLE → T1 when `req` = 1. `addr`, `wr`, `fetch` and `wdata` are latched on that edge. Later changes to these inputs have no effect until the next IDLE.
- T1 → T2 unconditionally.
- T2 → T3 unconditionally.
- T3 → T4 if `ready` = 1. Otherwise T3 → TW.
- TW → T4 if `ready` = 1. Otherwise stay in TW.
- T4 → IDLE unconditionally.
- `req` is ignored in all states except IDLE. No back-to-back acceptance from T4; there is at least one IDLE cycle between bus cycles.

Outputs are a Moore decode of the state plus the latched request, registered so they are valid during the state:
- `ale` = 1 in T1 only.
- `addr_bus` = latched address from T1 through T4. It holds its last value in IDLE.
- `dt_r` = 0 from T1 through T4 on writes; otherwise 1.
- Reads: `rd_n` = 0 and `den_n` = 0 in T2, T3 and TW.
- Writes: `wr_n` = 0 and `den_n` = 0 in T2, T3 and TW. `data_oe` = 1 and `data_out` = latched `wdata` in T2 through T4.
- `rdata` captures `data_in` on the edge that leaves T3 or TW with `ready` = 1. It holds that value until the next capture.
- `done` = 1 in T4.
- `q_en` = 1 in T4 only for a completed, non-timed-out read with `fetch` = 1.
- `busy` = 1 in T1 through T4.

Reset (`rst` = 0 at an edge), including in the middle of a cycle:
- Next state is IDLE.
- `ale`, `data_oe`, `done`, `q_en`, `busy` and `timeout` are 0.
- `rd_n`, `wr_n`, `den_n` and `dt_r` are 1.
- `addr_bus`, `data_out` and `rdata` are 0. The wait counter is 0.
- An aborted cycle produces no `done` and no `q_en`.

## Timing

- `req` is sampled at edge E0. T1 occupies the cycle after E0, then T2, T3 and T4.
- With zero wait states, `done` is high in the 4th cycle after E0 and `busy` is low in the 5th. Acceptance to `done` is 4 cycles.
- Each cycle of `ready` = 0 seen in T3 or TW adds exactly one TW cycle.
- `rdata` is valid in T4, coincident with `done` and `q_en`.
- Minimum request period is 5 cycles.

## Configuration

`BUS_TIMEOUT_EN` defined:
- A 4-bit wait counter is cleared in T1 and increments on every TW cycle.
- When `ready` = 0 in TW and the counter equals `MAX_WAIT`, the next state is T4 with `timeout` = 1 and `done` = 1.
- `rdata` is forced to 8'hFF, and `q_en` = 0.

`BUS_TIMEOUT_EN` undefined:
- No counter is built, and `timeout` is tied to 0.
- TW persists for as long as `ready` stays 0.

## Test plan

- Reset, then read with `addr` = 20'h12345, `fetch` = 0, `ready` = 1 and `data_in` = 8'hA5:
  - `ale` = 1 in cycle 1 with `addr_bus` = 20'h12345.
  - `rd_n` = 0 in cycles 2–3.
  - `done` = 1 in cycle 4 with `rdata` = 8'hA5 and `q_en` = 0.
- Write with `addr` = 20'hFFFF0 and `wdata` = 8'h3C, with `ready` held 0 for 2 cycles from T3:
  - Two TW states occur.
  - `wr_n` = 0 for 4 cycles and `dt_r` = 0.
  - `data_out` = 8'h3C with `data_oe` = 1 through T4.
  - `done` arrives in cycle 6.
- Fetch read with `data_in` = 8'h90: `q_en` pulses exactly once, in T4, with `rdata` = 8'h90.
- `req` held high continuously and `addr` changed during T2:
  - `addr_bus` keeps the originally latched address.
  - The next T1 starts only after one IDLE cycle.
- `rst` = 0 in TW during a fetch:
  - All outputs take their reset values at the next edge.
  - No `done` or `q_en` occurs, and `busy` = 0.
- With `BUS_TIMEOUT_EN`, `MAX_WAIT` = 15 and `ready` stuck at 0:
  - There are 16 TW cycles, then T4.
  - `timeout` = 1, `done` = 1, `rdata` = 8'hFF and `q_en` = 0.
  - Without the macro, `busy` stays 1 for 100+ cycles.

Source files
------------

// File: rtl/bus_cycle_ctrl.sv
// 8086-style T1..T4 external bus cycle sequencer with READY wait states.
// Latency: request sampled at E0, done pulses 4 cycles later plus one cycle per wait state.
// Backpressure: req is only accepted in IDLE; ready=0 in T3/TW inserts TW states.
//
// Ports:
//   clk, rst (sync, active-low)    - clock and reset
//   req, wr, fetch, addr, wdata    - cycle request from the address ALU (latched on acceptance)
//   ready, data_in                 - memory ready and byte from the I/O buffer
//   busy, done, timeout            - cycle status (done/timeout are single-cycle pulses in T4)
//   rdata, q_en                    - captured read byte and instruction queue load enable
//   ale, addr_bus, rd_n, wr_n,     - external bus control, address and data
//   den_n, dt_r, data_oe, data_out
//
// Build option: define BUS_TIMEOUT_EN to abort a cycle after MAX_WAIT+1 TW states.

module bus_cycle_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic        fetch,
    input  logic [19:0] addr,
    input  logic [7:0]  wdata,
    input  logic        ready,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  rdata,
    output logic        q_en,
    output logic        ale,
    output logic [19:0] addr_bus,
    output logic        rd_n,
    output logic        wr_n,
    output logic        den_n,
    output logic        dt_r,
    output logic        data_oe,
    output logic [7:0]  data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_TW,
        S_T4
    } state_t;

    state_t state;
    state_t state_nx;

    logic lat_wr;
    logic lat_fetch;
    logic accept;
    logic cyc_wr;
    logic cyc_fetch;
    logic ready_exit;
    logic strobe_nx;
    logic wait_hit;

`ifdef BUS_TIMEOUT_EN
    logic [3:0] wait_cnt;
    // Counter holds the number of TW cycles already completed, so the
    // MAX_WAIT-th compare fires on the (MAX_WAIT+1)-th TW cycle.
    assign wait_hit = (state == S_TW) && !ready && (wait_cnt == 4'(MAX_WAIT));
`else
    assign wait_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        accept     = (state == S_IDLE) && req;
        // Outputs are decoded from the next state, so on the accepting edge the
        // request attributes must come straight from the inputs.
        cyc_wr     = accept ? wr : lat_wr;
        cyc_fetch  = accept ? (fetch & ~wr) : lat_fetch;
        ready_exit = ((state == S_T3) || (state == S_TW)) && ready;

        state_nx = state;
        case (state)
            S_IDLE:  if (req) state_nx = S_T1;
            S_T1:    state_nx = S_T2;
            S_T2:    state_nx = S_T3;
            S_T3:    state_nx = ready ? S_T4 : S_TW;
            S_TW:    if (ready || wait_hit) state_nx = S_T4;
            S_T4:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        strobe_nx = (state_nx == S_T2) || (state_nx == S_T3) || (state_nx == S_TW);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            lat_wr    <= 1'b0;
            lat_fetch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            q_en      <= 1'b0;
            ale       <= 1'b0;
            addr_bus  <= 20'h0;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            den_n     <= 1'b1;
            dt_r      <= 1'b1;
            data_oe   <= 1'b0;
            data_out  <= 8'h0;
            rdata     <= 8'h0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt  <= 4'h0;
            timeout   <= 1'b0;
`endif
        end else begin
            state <= state_nx;

            if (accept) begin
                lat_wr    <= wr;
                lat_fetch <= fetch & ~wr;
                addr_bus  <= addr;
                if (wr) data_out <= wdata;
            end

            busy    <= (state_nx != S_IDLE);
            ale     <= (state_nx == S_T1);
            done    <= (state_nx == S_T4);
            dt_r    <= !(cyc_wr && (state_nx != S_IDLE));
            den_n   <= !strobe_nx;
            rd_n    <= !(strobe_nx && !cyc_wr);
            wr_n    <= !(strobe_nx && cyc_wr);
            data_oe <= cyc_wr && (strobe_nx || (state_nx == S_T4));
            q_en    <= (state_nx == S_T4) && !cyc_wr && cyc_fetch && !wait_hit;

            if (ready_exit) begin
                rdata <= data_in;
            end else if (wait_hit) begin
                rdata <= 8'hFF;
            end

`ifdef BUS_TIMEOUT_EN
            if (state == S_T1) begin
                wait_cnt <= 4'h0;
            end else if (state == S_TW) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            timeout <= wait_hit;
`endif
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
module tb_bus_cycle_ctrl;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic        fetch;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic [7:0]  data_in;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  rdata;
    logic        q_en;
    logic        ale;
    logic [19:0] addr_bus;
    logic        rd_n;
    logic        wr_n;
    logic        den_n;
    logic        dt_r;
    logic        data_oe;
    logic [7:0]  data_out;

    bus_cycle_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .fetch(fetch), .addr(addr),
        .wdata(wdata), .ready(ready), .data_in(data_in), .busy(busy), .done(done),
        .timeout(timeout), .rdata(rdata), .q_en(q_en), .ale(ale), .addr_bus(addr_bus),
        .rd_n(rd_n), .wr_n(wr_n), .den_n(den_n), .dt_r(dt_r), .data_oe(data_oe),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        is_wr;
        bit        is_fetch;
        bit [19:0] a;
        bit [7:0]  wd;
        bit [7:0]  rd;
        bit        to;
        int        nw;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl_low"}, {ale, data_oe, done, q_en, busy, timeout}, 0);
        chk({tag, "_ctl_high"}, {rd_n, wr_n, den_n, dt_r}, 4'hF);
        chk({tag, "_addr_bus"}, addr_bus, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // Issues one bus cycle: pushes the expected outcome, then scripts ready
    // and scrambles the request inputs while the cycle runs.
    task automatic do_cycle(input bit w_, input bit f_, input logic [19:0] a_,
                            input logic [7:0] wd_, input logic [7:0] di_,
                            input int waits, input bit hold);
        exp_t e;
        int   nw;
        bit   to;
        nw = waits;
        to = 1'b0;
`ifdef BUS_TIMEOUT_EN
        if (waits > MAXW) begin
            nw = MAXW + 1;
            to = 1'b1;
        end
`endif
        @(negedge clk);
        req = 1'b1; wr = w_; fetch = f_; addr = a_; wdata = wd_;
        ready = 1'($urandom); data_in = 8'($urandom);
        e.is_wr = w_; e.is_fetch = f_; e.a = a_; e.wd = wd_;
        e.rd = to ? 8'hFF : di_; e.to = to; e.nw = nw;
        sb.push_back(e);
        for (int k = 1; k <= 4 + nw; k++) begin
            @(negedge clk);
            req   = hold ? 1'b1 : 1'($urandom);
            wr    = 1'($urandom);
            fetch = 1'($urandom);
            addr  = 20'($urandom);
            wdata = 8'($urandom);
            if (k < 3) ready = 1'($urandom);
            else       ready = (k >= 3 + nw) && !to;
            data_in = (k == 3 + nw) ? di_ : 8'($urandom);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Monitor: per-cycle observation of the bus, compared to the scoreboard at done.
    initial begin : monitor
        int  cyc, n_ale, n_rd, n_wr, n_den, n_dtr, n_oe, n_qen, n_to;
        bit  prev_busy, chk_idle;
        exp_t e;
        cyc = 0; n_ale = 0; n_rd = 0; n_wr = 0; n_den = 0; n_dtr = 0; n_oe = 0;
        n_qen = 0; n_to = 0; prev_busy = 0; chk_idle = 0;
        forever begin
            @(negedge clk);
            if (chk_idle) begin
                chk("idle_after_t4", busy, 0);
                chk_idle = 0;
            end
            if (busy === 1'b1) begin
                if (!prev_busy) begin
                    cyc = 0; n_ale = 0; n_rd = 0; n_wr = 0; n_den = 0;
                    n_dtr = 0; n_oe = 0; n_qen = 0; n_to = 0;
                end
                cyc++;
                n_ale += int'(ale);
                n_rd  += int'(!rd_n);
                n_wr  += int'(!wr_n);
                n_den += int'(!den_n);
                n_dtr += int'(!dt_r);
                n_oe  += int'(data_oe);
                n_qen += int'(q_en);
                n_to  += int'(timeout);
                if (sb.size() > 0) begin
                    chk("addr_bus_held", addr_bus, sb[0].a);
                    if (data_oe === 1'b1) chk("data_out", data_out, sb[0].wd);
                end
                if (done === 1'b1) begin
                    chk_idle = 1;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", cyc, 4 + e.nw);
                        chk("ale_cycles", n_ale, 1);
                        chk("rd_n_low_cycles", n_rd, e.is_wr ? 0 : 2 + e.nw);
                        chk("wr_n_low_cycles", n_wr, e.is_wr ? 2 + e.nw : 0);
                        chk("den_n_low_cycles", n_den, 2 + e.nw);
                        chk("dt_r_low_cycles", n_dtr, e.is_wr ? 4 + e.nw : 0);
                        chk("data_oe_cycles", n_oe, e.is_wr ? 3 + e.nw : 0);
                        chk("q_en_at_done", q_en, (!e.is_wr && e.is_fetch && !e.to));
                        chk("q_en_pulses", n_qen, (!e.is_wr && e.is_fetch && !e.to) ? 1 : 0);
                        chk("timeout_at_done", timeout, e.to);
                        chk("timeout_pulses", n_to, e.to ? 1 : 0);
                        chk("rdata", rdata, e.rd);
                    end
                end
            end else if ((done === 1'b1) || (q_en === 1'b1)) begin
                failures++;
                $display("FAIL stray_pulse: got done=%0b q_en=%0b expected 0 while idle at %0t",
                         done, q_en, $time);
            end
            prev_busy = (busy === 1'b1);
        end
    end

    initial begin : stim
        int hold_cnt;
        rst = 1'b0; req = 1'b0; wr = 1'b0; fetch = 1'b0; addr = '0; wdata = '0;
        ready = 1'b1; data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;
        idle(2);

        // Plain read, zero waits.
        do_cycle(1'b0, 1'b0, 20'h12345, 8'h00, 8'hA5, 0, 1'b0);
        idle(1);
        // Write with two wait states.
        do_cycle(1'b1, 1'b0, 20'hFFFF0, 8'h3C, 8'h11, 2, 1'b0);
        idle(2);
        // Code fetch.
        do_cycle(1'b0, 1'b1, 20'h0ABCD, 8'h00, 8'h90, 0, 1'b0);
        // req held high across back-to-back cycles.
        do_cycle(1'b0, 1'b1, 20'h54321, 8'h00, 8'h42, 1, 1'b1);
        do_cycle(1'b1, 1'b0, 20'h00001, 8'h77, 8'h24, 0, 1'b1);
        do_cycle(1'b0, 1'b0, 20'hFEDCB, 8'h00, 8'h5A, 3, 1'b1);
        idle(2);

        // Reset in TW during a fetch: nothing is pushed, so any done is flagged.
        @(negedge clk);
        req = 1'b1; wr = 1'b0; fetch = 1'b1; addr = 20'h3C3C3; ready = 1'b0; data_in = 8'h66;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req = 1'b0;
            ready = 1'b0;
        end
        chk("tw_before_reset_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("midcycle_reset");
        rst = 1'b1;
        ready = 1'b1;
        idle(8);

`ifdef BUS_TIMEOUT_EN
        do_cycle(1'b0, 1'b1, 20'h77777, 8'h00, 8'h12, 40, 1'b0);
        idle(2);
`else
        // Without the timeout option TW persists indefinitely.
        @(negedge clk);
        req = 1'b1; wr = 1'b0; fetch = 1'b0; addr = 20'h0F0F0; ready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        hold_cnt = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            hold_cnt += int'(busy === 1'b1);
        end
        chk("no_timeout_busy_cycles", hold_cnt, 120);
        chk("no_timeout_flag", timeout, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ready = 1'b1;
        idle(3);
`endif

        // Randomised traffic.
        for (int i = 0; i < 30; i++) begin
            do_cycle(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 4)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(6);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
